// File: rtl/param_register_bank.sv
// Parametrised register bank: GPRs, read-only input ports, output port registers and W,
// with same-cycle write bypass, a one-deep load scoreboard, hazard stall and write-error flag.
module param_register_bank #(
   parameter int DATA_W    = 16,
   parameter int SEL_W     = 6,
   parameter int NUM_GPR   = 28,
   parameter int NUM_PI    = 2,
   parameter int NUM_PO    = 2,
   parameter int WREG_ADDR = 34
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SEL_W-1:0]         sel_a,
   input  logic [SEL_W-1:0]         sel_b,
   output logic [DATA_W-1:0]        data_a,
   output logic [DATA_W-1:0]        data_b,
   input  logic                     wr_c,
   input  logic [SEL_W-1:0]         sel_c,
   input  logic [DATA_W-1:0]        data_c,
   input  logic                     mr,
   input  logic                     mem_rvalid,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic [NUM_PI*DATA_W-1:0] pi,
   output logic [NUM_PO*DATA_W-1:0] po,
   output logic [DATA_W-1:0]        w_out,
   output logic                     stall,
   output logic                     wr_err
);

   localparam logic [SEL_W-1:0] PI_BASE = SEL_W'(NUM_GPR);
   localparam logic [SEL_W-1:0] PO_BASE = SEL_W'(NUM_GPR + NUM_PI);
   localparam logic [SEL_W-1:0] PO_END  = SEL_W'(NUM_GPR + NUM_PI + NUM_PO);
   localparam logic [SEL_W-1:0] W_ADDR  = SEL_W'(WREG_ADDR);

   typedef logic [NUM_GPR-1:0][DATA_W-1:0] gpr_t;
   typedef logic [NUM_PO-1:0][DATA_W-1:0]  po_t;
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
   gpr_t               gpr_q, gpr_d;
   po_t                po_q, po_d;
   logic [DATA_W-1:0]  w_q, w_d;
   logic               wr_err_q, wr_err_d;

   logic               stall_s;
   logic               ld_done_s;
   logic               ld_wr_s;
   logic               c_wr_s;
   logic               c_try_s;

   function automatic logic wr_legal(input logic [SEL_W-1:0] s);
      return (s < PI_BASE) || ((s >= PO_BASE) && (s < PO_END)) || (s == W_ADDR);
   endfunction

   // Stored value at an address; PI reads the live input, unmapped reads return zero.
   function automatic logic [DATA_W-1:0] rd_mux(input logic [SEL_W-1:0] s,
                                                input gpr_t g,
                                                input logic [NUM_PI*DATA_W-1:0] p_in,
                                                input po_t p_out,
                                                input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_GPR; i++) begin
         if (s == SEL_W'(i)) r = g[i];
      end
      for (int k = 0; k < NUM_PI; k++) begin
         if (s == SEL_W'(NUM_GPR + k)) r = p_in[k*DATA_W +: DATA_W];
      end
      for (int k = 0; k < NUM_PO; k++) begin
         if (s == SEL_W'(NUM_GPR + NUM_PI + k)) r = p_out[k];
      end
      if (s == W_ADDR) r = w;
      return r;
   endfunction

   assign stall_s   = (state_q == ST_WAIT) && !mem_rvalid &&
                      ((sel_a == pend_sel_q) || (sel_b == pend_sel_q) || mr ||
                       (wr_c && (sel_c == pend_sel_q)));
   assign ld_done_s = (state_q == ST_WAIT) && mem_rvalid;
   assign ld_wr_s   = ld_done_s && wr_legal(pend_sel_q);
   // mr takes precedence over a port C write presented in the same cycle.
   assign c_try_s   = wr_c && !mr && !stall_s;
   assign c_wr_s    = c_try_s && wr_legal(sel_c);

   assign data_a = (c_wr_s && (sel_c == sel_a))      ? data_c :
                   (ld_wr_s && (pend_sel_q == sel_a)) ? mem_rdata :
                   rd_mux(sel_a, gpr_q, pi, po_q, w_q);
   assign data_b = (c_wr_s && (sel_c == sel_b))      ? data_c :
                   (ld_wr_s && (pend_sel_q == sel_b)) ? mem_rdata :
                   rd_mux(sel_b, gpr_q, pi, po_q, w_q);

   assign po     = po_q;
   assign w_out  = w_q;
   assign stall  = stall_s;
   assign wr_err = wr_err_q;

   // Load FSM next state and pending destination.
   always_comb begin
      state_d    = state_q;
      pend_sel_d = pend_sel_q;
      case (state_q)
         ST_IDLE: begin
            if (mr) begin
               state_d    = ST_WAIT;
               pend_sel_d = sel_c;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Storage update: load completion first, then port C, so a newer port C write wins a tie.
   always_comb begin
      gpr_d = gpr_q;
      po_d  = po_q;
      w_d   = w_q;
      for (int i = 0; i < NUM_GPR; i++) begin
         gpr_d[i] = (ld_wr_s && (pend_sel_q == SEL_W'(i))) ? mem_rdata : gpr_d[i];
         gpr_d[i] = (c_wr_s && (sel_c == SEL_W'(i)))       ? data_c    : gpr_d[i];
      end
      for (int k = 0; k < NUM_PO; k++) begin
         po_d[k] = (ld_wr_s && (pend_sel_q == SEL_W'(NUM_GPR + NUM_PI + k))) ? mem_rdata : po_d[k];
         po_d[k] = (c_wr_s && (sel_c == SEL_W'(NUM_GPR + NUM_PI + k)))       ? data_c    : po_d[k];
      end
      w_d = (ld_wr_s && (pend_sel_q == W_ADDR)) ? mem_rdata : w_d;
      w_d = (c_wr_s && (sel_c == W_ADDR))       ? data_c    : w_d;
      wr_err_d = (c_try_s && !wr_legal(sel_c)) || (ld_done_s && !wr_legal(pend_sel_q));
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pend_sel_q <= '0;
         gpr_q      <= '0;
         po_q       <= '0;
         w_q        <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_sel_q <= pend_sel_d;
         gpr_q      <= gpr_d;
         po_q       <= po_d;
         w_q        <= w_d;
         wr_err_q   <= wr_err_d;
      end
   end

endmodule

// File: tb/tb_param_register_bank.sv
// Self-checking bench for param_register_bank: expectations queued at stimulus time,
// popped and compared at the falling edge.
module tb_param_register_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  sel_a, sel_b, sel_c;
   logic [15:0] data_a, data_b, data_c, mem_rdata, w_out;
   logic        wr_c, mr, mem_rvalid, stall, wr_err;
   logic [31:0] pi, po;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   param_register_bank dut (
      .clk(clk), .reset(reset), .sel_a(sel_a), .sel_b(sel_b),
      .data_a(data_a), .data_b(data_b), .wr_c(wr_c), .sel_c(sel_c),
      .data_c(data_c), .mr(mr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .pi(pi), .po(po), .w_out(w_out), .stall(stall), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_c       = 1'b0;
      mr         = 1'b0;
      mem_rvalid = 1'b0;
      data_c     = 16'h0000;
      mem_rdata  = 16'h0000;
   endtask

   task automatic test_reset();
      idle();
      pi = 32'h0000_0000;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL rst_stall: got %h expected %h", stall, e); end
      e = exp_q.pop_front(); checks++;
      if (po !== e) begin errors++; $display("FAIL rst_po: got %h expected %h", po, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, w_out} !== e) begin errors++; $display("FAIL rst_w: got %h expected %h", w_out, e); end
      tick();
      for (int a = 0; a < 64; a++) begin
         if (a < 28 || a == 30 || a == 31 || a == 34) begin
            wr_c = 1'b1; sel_c = 6'(a); data_c = 16'hFFFF;
            tick();
         end
      end
      idle();
      sel_a = 6'd0;
      exp_q.push_back(32'h0000_FFFF); exp_q.push_back(32'hFFFF_FFFF);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL fill_r0: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if (po !== e) begin errors++; $display("FAIL fill_po: got %h expected %h", po, e); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int a = 0; a < 64; a++) exp_q.push_back(32'h0);
      for (int a = 0; a < 64; a++) begin
         sel_a = 6'(a);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if ({16'h0, data_a} !== e) begin errors++; $display("FAIL rst_read_%0d: got %h expected %h", a, data_a, e); end
      end
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      e = exp_q.pop_front(); checks++;
      if (po !== e) begin errors++; $display("FAIL rst2_po: got %h expected %h", po, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, w_out} !== e) begin errors++; $display("FAIL rst2_w: got %h expected %h", w_out, e); end
      tick();
   endtask

   task automatic test_write_bypass();
      wr_c = 1'b1; sel_c = 6'd5; data_c = 16'h1234; sel_a = 6'd5; sel_b = 6'd6;
      exp_q.push_back(32'h1234); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL bypass_a: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL bypass_b: got %h expected %h", data_b, e); end
      tick();
      idle();
      exp_q.push_back(32'h1234);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL stored_r5: got %h expected %h", data_a, e); end
      tick();
   endtask

   task automatic test_illegal_write();
      pi = 32'hC0DE_BEEF;
      wr_c = 1'b1; sel_c = 6'd28; data_c = 16'h1111; sel_a = 6'd28; sel_b = 6'd29;
      exp_q.push_back(32'hBEEF); exp_q.push_back(32'hC0DE); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL pi0_rd: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL pi1_rd: got %h expected %h", data_b, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, wr_err} !== e) begin errors++; $display("FAIL pi_err_pre: got %h expected %h", wr_err, e); end
      tick();
      idle();
      exp_q.push_back(32'h1); exp_q.push_back(32'hBEEF);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, wr_err} !== e) begin errors++; $display("FAIL pi_err: got %h expected %h", wr_err, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL pi0_after: got %h expected %h", data_a, e); end
      tick();
      wr_c = 1'b1; sel_c = 6'd40; data_c = 16'h2222; sel_a = 6'd40;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, wr_err} !== e) begin errors++; $display("FAIL pi_err_once: got %h expected %h", wr_err, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL unmapped_rd: got %h expected %h", data_a, e); end
      tick();
      idle();
      exp_q.push_back(32'h1);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, wr_err} !== e) begin errors++; $display("FAIL unmapped_err: got %h expected %h", wr_err, e); end
      tick();
   endtask

   task automatic test_load();
      mr = 1'b1; sel_c = 6'd7; sel_a = 6'd0; sel_b = 6'd0;
      exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL load_req_stall: got %h expected %h", stall, e); end
      tick();
      mr = 1'b0; sel_b = 6'd7;
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(32'h1);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if ({31'b0, stall} !== e) begin errors++; $display("FAIL load_wait_stall_%0d: got %h expected %h", c, stall, e); end
         tick();
      end
      mem_rvalid = 1'b1; mem_rdata = 16'hA5A5;
      exp_q.push_back(32'h0); exp_q.push_back(32'hA5A5);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL load_rv_stall: got %h expected %h", stall, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL load_bypass: got %h expected %h", data_b, e); end
      tick();
      idle();
      exp_q.push_back(32'hA5A5);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL load_stored: got %h expected %h", data_b, e); end
      tick();
   endtask

   task automatic test_wait_hazards();
      mr = 1'b1; sel_c = 6'd7; sel_a = 6'd0; sel_b = 6'd0;
      tick();
      mr = 1'b0; wr_c = 1'b1; sel_c = 6'd3; data_c = 16'h0001; sel_a = 6'd3;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0001);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL wait_wr_stall: got %h expected %h", stall, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL wait_wr_bypass: got %h expected %h", data_a, e); end
      tick();
      wr_c = 1'b0; mr = 1'b1; sel_c = 6'd9; sel_a = 6'd0;
      exp_q.push_back(32'h1);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL wait_mr_stall: got %h expected %h", stall, e); end
      tick();
      mr = 1'b0; wr_c = 1'b1; sel_c = 6'd7; data_c = 16'h7777;
      exp_q.push_back(32'h1);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL wait_pend_wr_stall: got %h expected %h", stall, e); end
      tick();
      wr_c = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h5A5A; sel_a = 6'd7; sel_b = 6'd3;
      exp_q.push_back(32'h5A5A); exp_q.push_back(32'h0001);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL wait_done_a: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL wait_r3: got %h expected %h", data_b, e); end
      tick();
      mem_rdata = 16'hFFFF; sel_b = 6'd9;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL idle_rv_stall: got %h expected %h", stall, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL mr_ignored_r9: got %h expected %h", data_b, e); end
      tick();
      idle();
      exp_q.push_back(32'h5A5A);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL idle_rv_ignored: got %h expected %h", data_a, e); end
      tick();
   endtask

   task automatic test_ports();
      logic [5:0]  addrs [3];
      logic [15:0] vals  [3];
      addrs = '{6'd30, 6'd31, 6'd34};
      vals  = '{16'h00AA, 16'h00BB, 16'h00CC};
      for (int i = 0; i < 3; i++) begin
         wr_c = 1'b1; sel_c = addrs[i]; data_c = vals[i]; sel_a = addrs[i];
         exp_q.push_back({16'h0, vals[i]});
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if ({16'h0, data_a} !== e) begin errors++; $display("FAIL port_bypass_%0d: got %h expected %h", i, data_a, e); end
         tick();
      end
      idle();
      sel_a = 6'd30; sel_b = 6'd34;
      exp_q.push_back(32'h00BB_00AA); exp_q.push_back(32'h00CC); exp_q.push_back(32'h00AA); exp_q.push_back(32'h00CC);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (po !== e) begin errors++; $display("FAIL po_val: got %h expected %h", po, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, w_out} !== e) begin errors++; $display("FAIL w_val: got %h expected %h", w_out, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL po0_rd: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL w_rd: got %h expected %h", data_b, e); end
      tick();
   endtask

   task automatic test_reset_in_wait();
      mr = 1'b1; sel_c = 6'd12; sel_a = 6'd0; sel_b = 6'd0;
      tick();
      mr = 1'b0; sel_a = 6'd12;
      exp_q.push_back(32'h1);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL rw_stall: got %h expected %h", stall, e); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL rw_stall_after: got %h expected %h", stall, e); end
      e = exp_q.pop_front(); checks++;
      if (po !== e) begin errors++; $display("FAIL rw_po: got %h expected %h", po, e); end
      tick();
      mem_rvalid = 1'b1; mem_rdata = 16'h1357; sel_b = 6'd7;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL rw_no_bypass: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL rw_r7_cleared: got %h expected %h", data_b, e); end
      tick();
      idle();
      exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL rw_r12: got %h expected %h", data_a, e); end
      tick();
   endtask

   task automatic test_back_to_back();
      mr = 1'b1; sel_c = 6'd10;
      tick();
      mr = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h0A0A;
      wr_c = 1'b1; sel_c = 6'd11; data_c = 16'h0B0B; sel_a = 6'd10; sel_b = 6'd11;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0A0A); exp_q.push_back(32'h0B0B);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL b2b_stall: got %h expected %h", stall, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL b2b_ld_bypass: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL b2b_wr_bypass: got %h expected %h", data_b, e); end
      tick();
      idle();
      mr = 1'b1; sel_c = 6'd28;
      exp_q.push_back(32'h0A0A); exp_q.push_back(32'h0B0B); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL b2b_r10: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_b} !== e) begin errors++; $display("FAIL b2b_r11: got %h expected %h", data_b, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL b2b_mr2_stall: got %h expected %h", stall, e); end
      tick();
      mr = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h9999; sel_a = 6'd28;
      exp_q.push_back(32'hBEEF); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL ld_pi_rd: got %h expected %h", data_a, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, wr_err} !== e) begin errors++; $display("FAIL ld_pi_err_pre: got %h expected %h", wr_err, e); end
      tick();
      idle();
      exp_q.push_back(32'h1); exp_q.push_back(32'hBEEF);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({31'b0, wr_err} !== e) begin errors++; $display("FAIL ld_pi_err: got %h expected %h", wr_err, e); end
      e = exp_q.pop_front(); checks++;
      if ({16'h0, data_a} !== e) begin errors++; $display("FAIL ld_pi_kept: got %h expected %h", data_a, e); end
      tick();
   endtask

   initial begin
      reset = 1'b1;
      sel_a = 6'd0; sel_b = 6'd0; sel_c = 6'd0;
      pi    = 32'h0;
      idle();
      tick();
      tick();
      reset = 1'b0;
      test_reset();
      test_write_bypass();
      test_illegal_write();
      test_load();
      test_wait_hazards();
      test_ports();
      test_reset_in_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
